// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Time-multiplexed N-digit 7-segment driver with hex/BCD decode,
//               per-digit decimal points, leading-zero blanking, anti-ghosting
//               guard and a double-buffered (shadow/display) digit store that
//               only updates at frame boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 1024,
    parameter int GUARD        = 2,
    parameter int COMMON_ANODE = 0,
    parameter int HEX_MODE     = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic                      load,
    input  logic [$clog2(DIGITS)-1:0] wr_addr,
    input  logic [3:0]                wr_data,
    input  logic                      wr_dp,
    input  logic                      commit,
    input  logic                      blank_lz,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [DIGITS-1:0]         digit_en,
    output logic                      frame_done,
    output logic                      commit_pending
);

    localparam int                 c_aw    = $clog2(DIGITS);
    localparam int                 c_pw    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_pw-1:0]    c_plast = c_pw'(PRESCALE - 1);
    localparam logic [c_pw-1:0]    c_guard = c_pw'(GUARD);
    localparam logic [c_aw-1:0]    c_slast = c_aw'(DIGITS - 1);
    localparam logic               c_inv   = (COMMON_ANODE != 0);
    localparam logic [DIGITS-1:0]  c_one   = DIGITS'(1);

    // Scan position
    logic [c_pw-1:0]            r_pcnt;
    logic [c_aw-1:0]            r_sidx;

    // Shadow and display banks
    logic [DIGITS-1:0][3:0]     r_sh_nib;
    logic [DIGITS-1:0]          r_sh_dp;
    logic [DIGITS-1:0][3:0]     r_ds_nib;
    logic [DIGITS-1:0]          r_ds_dp;

    logic                       r_pend;

    logic                       w_boundary;
    logic [DIGITS-1:0]          w_wr_hit;
    logic [3:0]                 w_cur_nib;
    logic                       w_cur_dp;
    logic                       w_cur_lz;
    logic                       w_all_zero;
    logic [6:0]                 w_seg;
    logic [DIGITS-1:0]          w_en;

    // Hex decode, active-high segments (bit0=a .. bit6=g)
    function automatic logic [6:0] f_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        if ((HEX_MODE == 0) && (n > 4'd9)) begin
            s = 7'h00;
        end
        return s;
    endfunction

    // The frame boundary is the advancing cycle in which the last slot ends
    assign w_boundary = ena && (r_pcnt == c_plast) && (r_sidx == c_slast);

    // Per-digit write strobes; addresses beyond DIGITS-1 match nothing
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_wr_hit
        assign w_wr_hit[gi] = load && (wr_addr == c_aw'(gi));
    end

    // Prescaler and scan index advance only while enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcnt <= '0;
            r_sidx <= '0;
        end else if (ena) begin
            if (r_pcnt == c_plast) begin
                r_pcnt <= '0;
                r_sidx <= (r_sidx == c_slast) ? '0 : r_sidx + 1'b1;
            end else begin
                r_pcnt <= r_pcnt + 1'b1;
            end
        end
    end

    // Shadow bank takes writes at any time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_nib <= '0;
            r_sh_dp  <= '0;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                if (w_wr_hit[i]) begin
                    r_sh_nib[i] <= wr_data;
                    r_sh_dp[i]  <= wr_dp;
                end
            end
        end
    end

    // Display bank copies the pre-write shadow at a boundary with a commit outstanding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ds_nib <= '0;
            r_ds_dp  <= '0;
        end else if (w_boundary && (r_pend || commit)) begin
            r_ds_nib <= r_sh_nib;
            r_ds_dp  <= r_sh_dp;
        end
    end

    // Commit tracking and frame pulse; a boundary always retires the request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= w_boundary;
            if (w_boundary) begin
                r_pend <= 1'b0;
            end else if (commit) begin
                r_pend <= 1'b1;
            end
        end
    end

    assign commit_pending = r_pend;

    // Select the scanned digit and decide whether it is a leading zero
    always_comb begin
        w_cur_nib  = 4'h0;
        w_cur_dp   = 1'b0;
        w_cur_lz   = 1'b0;
        w_all_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_all_zero = w_all_zero && (r_ds_nib[i] == 4'h0);
            if (r_sidx == c_aw'(i)) begin
                w_cur_nib = r_ds_nib[i];
                w_cur_dp  = r_ds_dp[i];
                w_cur_lz  = w_all_zero && (i != 0);
            end
        end
        w_seg = (blank_lz && w_cur_lz) ? 7'h00 : f_decode(w_cur_nib);
        w_en  = (r_pcnt < c_guard) ? '0 : (c_one << r_sidx);
    end

    // Registered, polarity-adjusted outputs; frozen while scanning is disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg      <= {7{c_inv}};
            dp       <= c_inv;
            digit_en <= {DIGITS{c_inv}};
        end else if (ena) begin
            seg      <= w_seg ^ {7{c_inv}};
            dp       <= w_cur_dp ^ c_inv;
            digit_en <= w_en ^ {DIGITS{c_inv}};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Directed self-checking bench for seg7_scan_driver. Three
//               instances (hex, BCD, common-anode) share one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       load = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic       wr_dp = 1'b0;
    logic       commit = 1'b0;
    logic       blank_lz = 1'b0;

    logic [6:0] seg, seg_b, seg_c;
    logic       dp, dp_b, dp_c;
    logic [3:0] den, den_b, den_c;
    logic       fd, fd_b, fd_c;
    logic       cp, cp_b, cp_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIGITS(4), .PRESCALE(4), .GUARD(1), .COMMON_ANODE(0), .HEX_MODE(1)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .load(load), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_dp(wr_dp), .commit(commit), .blank_lz(blank_lz),
        .seg(seg), .dp(dp), .digit_en(den), .frame_done(fd), .commit_pending(cp));

    seg7_scan_driver #(.DIGITS(4), .PRESCALE(4), .GUARD(1), .COMMON_ANODE(0), .HEX_MODE(0)) dut_bcd (
        .clk(clk), .rst_n(rst_n), .ena(ena), .load(load), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_dp(wr_dp), .commit(commit), .blank_lz(blank_lz),
        .seg(seg_b), .dp(dp_b), .digit_en(den_b), .frame_done(fd_b), .commit_pending(cp_b));

    seg7_scan_driver #(.DIGITS(4), .PRESCALE(4), .GUARD(1), .COMMON_ANODE(1), .HEX_MODE(1)) dut_ca (
        .clk(clk), .rst_n(rst_n), .ena(ena), .load(load), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_dp(wr_dp), .commit(commit), .blank_lz(blank_lz),
        .seg(seg_c), .dp(dp_c), .digit_en(den_c), .frame_done(fd_c), .commit_pending(cp_c));

    typedef struct {
        logic [15:0] val;   // digit3..digit0 nibbles
        logic [3:0]  dps;
        logic        blz;
        logic [27:0] hex;   // expected seg, digit i at [7i+6:7i]
        logic [27:0] bcd;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        while (!fd && n < 60) begin
            tick();
            n++;
        end
        check("frame_done_timeout", {31'd0, fd}, 32'd1);
    endtask

    task automatic seek_digit(input int k);
        int n;
        logic [3:0] want;
        want = 4'b0001 << k;
        n = 0;
        while (den !== want && n < 60) begin
            tick();
            n++;
        end
        check("seek_digit_timeout", {28'd0, den}, {28'd0, want});
    endtask

    initial begin
        logic [6:0] es, eb;
        logic [3:0] een;
        logic [3:0] rel_en[8];
        int n;

        vecs[0] = '{16'hA769, 4'b0010, 1'b0, {7'h77, 7'h07, 7'h7D, 7'h6F}, {7'h00, 7'h07, 7'h7D, 7'h6F}};
        vecs[1] = '{16'h0040, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h66, 7'h3F}, {7'h00, 7'h00, 7'h66, 7'h3F}};
        vecs[2] = '{16'h0000, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}, {7'h00, 7'h00, 7'h00, 7'h3F}};
        vecs[3] = '{16'h0000, 4'b0000, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, {7'h3F, 7'h3F, 7'h3F, 7'h3F}};
        vecs[4] = '{16'h1F0B, 4'b1001, 1'b0, {7'h06, 7'h71, 7'h3F, 7'h7C}, {7'h06, 7'h00, 7'h3F, 7'h00}};
        vecs[5] = '{16'h0C05, 4'b1111, 1'b1, {7'h00, 7'h39, 7'h3F, 7'h6D}, {7'h00, 7'h00, 7'h3F, 7'h6D}};
        vecs[6] = '{16'h8E2D, 4'b0100, 1'b0, {7'h7F, 7'h79, 7'h5B, 7'h5E}, {7'h7F, 7'h00, 7'h5B, 7'h00}};

        rel_en = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0010};

        // ---------------- reset state ----------------
        tick(); tick(); tick();
        check("rst_seg", {25'd0, seg}, 32'h00);
        check("rst_den", {28'd0, den}, 32'h0);
        check("rst_cp", {31'd0, cp}, 32'd0);
        check("rst_fd", {31'd0, fd}, 32'd0);
        check("rst_ca_seg", {25'd0, seg_c}, 32'h7F);
        check("rst_ca_den", {28'd0, den_c}, 32'hF);
        check("rst_ca_dp", {31'd0, dp_c}, 32'd1);

        // ---------------- release and scan sequence ----------------
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rel_den", {28'd0, den}, {28'd0, rel_en[i]});
            check("rel_seg", {25'd0, seg}, 32'h3F);
            check("rel_ca_den", {28'd0, den_c}, {28'd0, ~rel_en[i]});
        end
        wait_frame();
        n = 0;
        do begin
            tick();
            n++;
        end while (!fd && n < 60);
        check("frame_period", n, 32'd16);

        // ---------------- table-driven decode vectors ----------------
        for (int v = 0; v < 7; v++) begin
            blank_lz = vecs[v].blz;
            for (int d = 0; d < 4; d++) begin
                load = 1'b1;
                wr_addr = 2'(d);
                wr_data = vecs[v].val[4*d +: 4];
                wr_dp = vecs[v].dps[d];
                tick();
            end
            load = 1'b0;
            commit = 1'b1;
            tick();
            commit = 1'b0;
            wait_frame();
            for (int s = 0; s < 4; s++) begin
                es = vecs[v].hex[7*s +: 7];
                eb = vecs[v].bcd[7*s +: 7];
                een = 4'b0001 << s;
                tick();
                check("vec_guard_den", {28'd0, den}, 32'h0);
                check("vec_guard_seg", {25'd0, seg}, {25'd0, es});
                check("vec_guard_ca_den", {28'd0, den_c}, 32'hF);
                for (int c = 0; c < 3; c++) begin
                    tick();
                    check("vec_den", {28'd0, den}, {28'd0, een});
                    check("vec_seg", {25'd0, seg}, {25'd0, es});
                    check("vec_dp", {31'd0, dp}, {31'd0, vecs[v].dps[s]});
                    check("vec_bcd_seg", {25'd0, seg_b}, {25'd0, eb});
                    check("vec_ca_seg", {25'd0, seg_c}, {25'd0, ~es});
                    check("vec_ca_dp", {31'd0, dp_c}, {31'd0, ~vecs[v].dps[s]});
                    check("vec_ca_den", {28'd0, den_c}, {28'd0, ~een});
                end
            end
        end

        // ---------------- commit mid-frame (display 8E2D) ----------------
        blank_lz = 1'b0;
        wait_frame();
        tick();
        load = 1'b1; wr_addr = 2'd0; wr_data = 4'h3; wr_dp = 1'b0;
        tick();
        load = 1'b0;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check("mid_cp_rise", {31'd0, cp}, 32'd1);
        check("mid_old_digit0", {25'd0, seg}, 32'h5E);
        n = 0;
        while (!fd && n < 60) begin
            check("mid_cp_held", {31'd0, cp}, 32'd1);
            tick();
            n++;
        end
        check("mid_fd_seen", {31'd0, fd}, 32'd1);
        check("mid_cp_clear", {31'd0, cp}, 32'd0);
        tick(); tick();
        check("mid_new_digit0", {25'd0, seg}, 32'h4F);

        // ---------------- load + commit in the boundary cycle ----------------
        wait_frame();
        tick();
        load = 1'b1; wr_addr = 2'd2; wr_data = 4'h5;
        tick();
        load = 1'b0;
        for (int i = 0; i < 13; i++) tick();
        load = 1'b1; wr_addr = 2'd1; wr_data = 4'h9; commit = 1'b1;
        tick();
        load = 1'b0; commit = 1'b0;
        check("bnd_fd", {31'd0, fd}, 32'd1);
        check("bnd_cp", {31'd0, cp}, 32'd0);
        seek_digit(1);
        check("bnd_digit1_old", {25'd0, seg}, 32'h5B);
        seek_digit(2);
        check("bnd_digit2_new", {25'd0, seg}, 32'h6D);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        wait_frame();
        seek_digit(1);
        check("bnd_digit1_later", {25'd0, seg}, 32'h6F);

        // ---------------- ena freeze ----------------
        wait_frame();
        for (int i = 0; i < 6; i++) tick();
        check("frz_pre_den", {28'd0, den}, 32'h2);
        ena = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("frz_den", {28'd0, den}, 32'h2);
            check("frz_seg", {25'd0, seg}, 32'h6F);
        end
        ena = 1'b1;
        n = 16;
        while (!fd && n < 80) begin
            tick();
            n++;
        end
        check("frz_frame_len", n, 32'd26);

        // ---------------- async reset with commit pending ----------------
        seek_digit(2);
        load = 1'b1; wr_addr = 2'd3; wr_data = 4'h7; commit = 1'b1;
        tick();
        load = 1'b0; commit = 1'b0;
        check("ar_cp_set", {31'd0, cp}, 32'd1);
        check("ar_den_active", {28'd0, den}, 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_den", {28'd0, den}, 32'h0);
        check("ar_seg", {25'd0, seg}, 32'h00);
        check("ar_cp", {31'd0, cp}, 32'd0);
        check("ar_ca_seg", {25'd0, seg_c}, 32'h7F);
        check("ar_ca_den", {28'd0, den_c}, 32'hF);
        tick();
        rst_n = 1'b1;
        for (int d = 0; d < 4; d++) begin
            seek_digit(d);
            check("ar_bank_seg", {25'd0, seg}, 32'h3F);
            check("ar_bank_dp", {31'd0, dp}, 32'd0);
        end
        wait_frame();
        check("ar_cp_after", {31'd0, cp}, 32'd0);
        seek_digit(3);
        check("ar_pending_dropped", {25'd0, seg}, 32'h3F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
